fractal_sync_wrr_arb: RTL and testbench
=======================================

# fractal_sync_wrr_arb

Weighted round-robin arbiter that shares one downstream request/response channel among several FIFO-fronted sources in the fractal synchronization tree. Each source exposes an empty flag and a FIFO head; the block grants one source at a time, drains up to its programmed weight of elements through a valid/ready output, then rotates priority. It sits between node RX/TX FIFOs and a single-issue consumer, such as a serialized control-core port or an out-of-tree link.

## Interface
- `N_IN`, default 4: number of source FIFOs (≥2).
- `WEIGHT_WIDTH`, default 4: width of per-source weight (burst length).
- `arbiter_t`, default logic: element type carried through.
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_i`  in  1  reset, synchronous and active-high.
- `empty_i[N_IN]`  in  1 each  source FIFO empty flag.
- `element_i[N_IN]`  in  arbiter_t each  source FIFO head.
- `pop_o[N_IN]`  out  1 each  pop strobe to source FIFO.
- `weight_i[N_IN]`  in  WEIGHT_WIDTH each  max consecutive transfers per grant.
- `valid_o`  out  1  element_o valid.
- `element_o`  out  arbiter_t  granted element.
- `ready_i`  in  1  consumer accepts element_o.
- `grant_idx_o`  out  $clog2(N_IN)  current owner index.
- `busy_o`  out  1  state == SERVE.

## Operation
- State: `state` ∈ {IDLE, SERVE}, `ptr` (priority start index), `owner`, `cnt` (WEIGHT_WIDTH bits).
- Reset values: state=IDLE, ptr=0, owner=0, cnt=0.
- Output reset values: valid_o=0, pop_o all 0, element_o='0, grant_idx_o=0, busy_o=0.
- IDLE:
  - Search indices ptr, ptr+1, …, ptr+N_IN−1 (mod N_IN) for the first source with `empty_i=0`.
  - If one is found: owner←index; cnt←weight_i[index], with a weight of 0 treated as 1; state←SERVE.
  - If none is found: remain in IDLE; ptr is unchanged.
  - weight_i is sampled only at grant.
- SERVE:
  - valid_o = !empty_i[owner].
  - element_o = element_i[owner] when valid_o=1, else '0.
  - A transfer occurs when valid_o && ready_i. On that cycle pop_o[owner]=1, combinationally in the same cycle; all other pop_o bits are 0.
  - Transfer with cnt>1: cnt←cnt−1; stay in SERVE.
  - Transfer with cnt==1: release.
  - empty_i[owner]=1 in SERVE (no transfer possible): release, regardless of ready_i.
- Release: ptr←(owner+1) mod N_IN; state←IDLE; cnt←0.
- grant_idx_o = owner at all times. busy_o = (state==SERVE).
- ready_i with valid_o=0 is ignored. valid_o is never asserted in IDLE.
- Once valid_o rises, element_o and valid_o are held stable until ready_i. The block never withdraws valid_o while the owner is non-empty.

## Timing
- Grant latency: a source observed non-empty in IDLE at cycle t gives valid_o=1 at cycle t+1. No combinational path from empty_i to valid_o in IDLE.
- Throughput per grant: up to W transfers on consecutive cycles while ready_i=1. Each grant costs one IDLE arbitration cycle, so the peak rate is W/(W+1).
- Release on an empty owner costs one SERVE cycle plus one IDLE cycle before the next grant.
- Wrap-around: ptr rolls from N_IN−1 to 0. The cnt decrement never underflows because release occurs at cnt==1.
- Simultaneous events: when a transfer and cnt==1 coincide, the pop is issued and the release occurs on the same edge.
- Reset mid-operation: rst_i=1 forces all pop_o=0 and valid_o=0 in that cycle. On the next edge all state returns to reset values. No partial burst state is retained.

## Test plan
- Single source: reset; empty_i[2]=0 with 3 elements queued, weight_i[2]=2, ready_i=1. Required response:
  - valid_o=1 one cycle after the first IDLE sample.
  - 2 pops on consecutive cycles, then one IDLE cycle.
  - 1 more pop; then release on empty; ptr ends at 3.
- Round-robin fairness: all 4 sources non-empty, all weights=1, ready_i=1. Required grant order 0,1,2,3,0,… with one pop every 2 cycles.
- Weight 0 and maximum weight: weight_i[0]=0 gives exactly 1 pop per grant. weight_i[1]=15 with 20 queued gives 15 pops per grant before rotation to source 2.
- Backpressure: ready_i=0 for 5 cycles while valid_o=1. Required response:
  - element_o stable, no pop_o.
  - cnt unchanged (no pop_o until ready_i returns).
  - Then ready_i=1 completes the burst normally.
- Owner drains early: weight 4, only 2 elements. Required response: 2 pops; empty_i[owner]=1 causes release; the next non-empty source is granted 2 cycles later.
- Reset mid-burst: assert rst_i on the cycle of the 2nd pop of a weight-3 burst. Required response:
  - pop_o=0 and valid_o=0 that cycle.
  - After reset, ptr=0; the next grant goes to the lowest-index non-empty source.

Source files
------------

// File: rtl/fractal_sync_wrr_arb.sv
// Weighted round-robin arbiter: grants one non-empty source FIFO at a time,
// drains up to its weight through a valid/ready port, then rotates priority.
module fractal_sync_wrr_arb #(
  parameter int unsigned N_IN         = 4,
  parameter int unsigned WEIGHT_WIDTH = 4,
  parameter type         arbiter_t    = logic,
  localparam int unsigned IDX_W       = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_IN-1:0]         empty_i,
  input  arbiter_t                element_i [N_IN],
  output logic [N_IN-1:0]         pop_o,
  input  logic [WEIGHT_WIDTH-1:0] weight_i [N_IN],
  output logic                    valid_o,
  output arbiter_t                element_o,
  input  logic                    ready_i,
  output logic [IDX_W-1:0]        grant_idx_o,
  output logic                    busy_o
);

  typedef enum logic {IDLE, SERVE} state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic [WEIGHT_WIDTH-1:0] cnt_q, cnt_d;

  logic             found;
  logic [IDX_W-1:0] pick;
  logic             owner_empty;
  logic             xfer;

  // First non-empty source scanning upward from ptr, wrapping at N_IN.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      logic [IDX_W-1:0] idx;
      idx = IDX_W'((32'(ptr_q) + i) % N_IN);
      if (!found && !empty_i[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign owner_empty = empty_i[owner_q];
  assign valid_o     = !rst_i && (state_q == SERVE) && !owner_empty;
  assign xfer        = valid_o && ready_i;
  assign element_o   = valid_o ? element_i[owner_q] : '0;
  assign grant_idx_o = owner_q;
  assign busy_o      = (state_q == SERVE);

  for (genvar g = 0; g < N_IN; g++) begin : g_pop
    assign pop_o[g] = xfer && (owner_q == IDX_W'(g));
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          owner_d = pick;
          cnt_d   = (weight_i[pick] == '0) ? WEIGHT_WIDTH'(1) : weight_i[pick];
          state_d = SERVE;
        end
      end
      SERVE: begin
        // An empty owner gives up the grant even if the burst is unfinished.
        if (owner_empty || (xfer && cnt_q == WEIGHT_WIDTH'(1))) begin
          ptr_d   = IDX_W'((32'(owner_q) + 32'd1) % N_IN);
          cnt_d   = '0;
          state_d = IDLE;
        end else if (xfer) begin
          cnt_d = cnt_q - WEIGHT_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fractal_sync_wrr_arb.sv
// Bench for fractal_sync_wrr_arb: directed scenarios plus random traffic,
// all checked against a FIFO-level behavioural model of the arbitration rules.
module tb_fractal_sync_wrr_arb;
  localparam int N  = 4;
  localparam int WW = 4;
  localparam int D  = 512;
  typedef logic [7:0] elem_t;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [N-1:0]  empty_i;
  elem_t         element_i [N];
  logic [N-1:0]  pop_o;
  logic [WW-1:0] weight_i [N];
  logic          valid_o;
  elem_t         element_o;
  logic          ready_i;
  logic [1:0]    grant_idx_o;
  logic          busy_o;

  always #5 clk = ~clk;

  fractal_sync_wrr_arb #(.N_IN(N), .WEIGHT_WIDTH(WW), .arbiter_t(elem_t)) dut (
    .clk_i(clk), .rst_i(rst_i), .empty_i(empty_i), .element_i(element_i),
    .pop_o(pop_o), .weight_i(weight_i), .valid_o(valid_o), .element_o(element_o),
    .ready_i(ready_i), .grant_idx_o(grant_idx_o), .busy_o(busy_o));

  // Source FIFOs as ring buffers
  elem_t mem [N][D];
  int    rd [N];
  int    wr [N];
  int    seqv = 1;

  logic          rst_r = 1'b0;
  logic          ready_r = 1'b1;
  logic [WW-1:0] w_r [N];

  // Reference model state: holder of the grant, transfers left, scan start
  bit   m_busy = 0;
  int   m_owner = 0, m_left = 0, m_start = 0;

  logic          exp_valid, exp_busy;
  logic [N-1:0]  exp_pop;
  elem_t         exp_elem;
  logic [1:0]    exp_grant;

  int errors = 0;
  int checks = 0;

  task automatic push(input int s);
    mem[s][wr[s] % D] = elem_t'(seqv);
    seqv = seqv + 37;
    wr[s]++;
  endtask

  task automatic clear_fifos();
    for (int s = 0; s < N; s++) begin rd[s] = 0; wr[s] = 0; end
  endtask

  // Apply inputs on the falling edge and compute what the outputs must be
  task automatic drive();
    @(negedge clk);
    rst_i   = rst_r;
    ready_i = ready_r;
    for (int s = 0; s < N; s++) begin
      empty_i[s]   = (wr[s] == rd[s]);
      element_i[s] = empty_i[s] ? elem_t'($urandom) : mem[s][rd[s] % D];
      weight_i[s]  = w_r[s];
    end
    #1;
    exp_busy  = m_busy;
    exp_grant = 2'(m_owner);
    exp_valid = 1'b0;
    exp_pop   = '0;
    exp_elem  = '0;
    if (!rst_r && m_busy && wr[m_owner] != rd[m_owner]) begin
      exp_valid        = 1'b1;
      exp_elem         = mem[m_owner][rd[m_owner] % D];
      exp_pop[m_owner] = ready_r;
    end
  endtask

  task automatic release_grant();
    m_start = (m_owner + 1) % N;
    m_busy  = 0;
    m_left  = 0;
  endtask

  // Advance model and FIFOs across the rising edge
  task automatic commit();
    @(posedge clk);
    if (rst_r) begin
      m_busy = 0; m_owner = 0; m_left = 0; m_start = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        int s;
        s = (m_start + k) % N;
        if (wr[s] != rd[s]) begin
          m_busy  = 1;
          m_owner = s;
          m_left  = (w_r[s] == 0) ? 1 : int'(w_r[s]);
          break;
        end
      end
    end else if (!exp_valid) begin
      release_grant();
    end else if (exp_pop[m_owner]) begin
      rd[m_owner]++;
      if (m_left == 1) release_grant();
      else m_left--;
    end
  endtask

  task automatic do_reset();
    clear_fifos();
    for (int s = 0; s < N; s++) w_r[s] = 4'd1;
    ready_r = 1'b1;
    rst_r   = 1'b1;
    drive();
    commit();
    rst_r = 1'b0;
  endtask

  task automatic test_reset();
    clear_fifos();
    for (int s = 0; s < N; s++) w_r[s] = 4'd2;
    push(0); push(1);
    ready_r = 1'b1;
    rst_r   = 1'b1;
    drive(); commit();
    for (int c = 0; c < 3; c++) begin
      drive();
      checks++;
      if (valid_o !== exp_valid || pop_o !== exp_pop || element_o !== exp_elem || grant_idx_o !== exp_grant || busy_o !== exp_busy) begin
        errors++;
        $display("FAIL reset c=%0d got v=%b p=%b e=%h g=%0d b=%b want v=%b p=%b e=%h g=%0d b=%b", c, valid_o, pop_o, element_o, grant_idx_o, busy_o, exp_valid, exp_pop, exp_elem, exp_grant, exp_busy);
      end
      if (c == 0) begin
        checks++;
        if ({valid_o, pop_o, busy_o, grant_idx_o, element_o} !== '0) begin
          errors++;
          $display("FAIL reset_outputs got v=%b p=%b b=%b g=%0d e=%h want all zero", valid_o, pop_o, busy_o, grant_idx_o, element_o);
        end
      end
      commit();
      rst_r = 1'b0;
    end
  endtask

  task automatic test_single_source();
    int npop;
    do_reset();
    w_r[2] = 4'd2;
    push(2); push(2); push(2);
    npop = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 6) begin push(0); push(3); end
      drive();
      checks++;
      if (valid_o !== exp_valid || pop_o !== exp_pop || element_o !== exp_elem || grant_idx_o !== exp_grant || busy_o !== exp_busy) begin
        errors++;
        $display("FAIL single c=%0d got v=%b p=%b e=%h g=%0d b=%b want v=%b p=%b e=%h g=%0d b=%b", c, valid_o, pop_o, element_o, grant_idx_o, busy_o, exp_valid, exp_pop, exp_elem, exp_grant, exp_busy);
      end
      if (pop_o[2]) begin
        npop++;
        checks++;
        if (!(c inside {1, 2, 4})) begin
          errors++;
          $display("FAIL single_pop_cycle got pop at c=%0d want c in {1,2,4}", c);
        end
      end
      if (c == 1) begin
        checks++;
        if (valid_o !== 1'b1) begin errors++; $display("FAIL single_latency got valid=%b want 1", valid_o); end
      end
      if (c == 7) begin
        checks++;
        if (grant_idx_o !== 2'd3 || busy_o !== 1'b1) begin
          errors++;
          $display("FAIL single_ptr got g=%0d b=%b want g=3 b=1", grant_idx_o, busy_o);
        end
      end
      commit();
    end
    checks++;
    if (npop != 3) begin errors++; $display("FAIL single_pops got %0d want 3", npop); end
  endtask

  task automatic test_round_robin();
    int npop;
    do_reset();
    for (int s = 0; s < N; s++) begin push(s); push(s); push(s); end
    npop = 0;
    for (int c = 0; c < 16; c++) begin
      drive();
      checks++;
      if (valid_o !== exp_valid || pop_o !== exp_pop || element_o !== exp_elem || grant_idx_o !== exp_grant || busy_o !== exp_busy) begin
        errors++;
        $display("FAIL rr c=%0d got v=%b p=%b e=%h g=%0d b=%b want v=%b p=%b e=%h g=%0d b=%b", c, valid_o, pop_o, element_o, grant_idx_o, busy_o, exp_valid, exp_pop, exp_elem, exp_grant, exp_busy);
      end
      if (pop_o != '0) begin
        checks++;
        if (pop_o !== (4'b0001 << (npop % N)) || (c % 2) != 1) begin
          errors++;
          $display("FAIL rr_order c=%0d got pop=%b want %b on odd cycle", c, pop_o, 4'b0001 << (npop % N));
        end
        npop++;
      end
      commit();
    end
    checks++;
    if (npop != 8) begin errors++; $display("FAIL rr_pops got %0d want 8", npop); end
  endtask

  task automatic test_weights();
    int npop, want;
    do_reset();
    w_r[0] = 4'd0; w_r[1] = 4'd15;
    for (int i = 0; i < 3; i++) push(0);
    for (int i = 0; i < 20; i++) push(1);
    push(2); push(2);
    npop = 0;
    for (int c = 0; c < 20; c++) begin
      drive();
      checks++;
      if (valid_o !== exp_valid || pop_o !== exp_pop || element_o !== exp_elem || grant_idx_o !== exp_grant || busy_o !== exp_busy) begin
        errors++;
        $display("FAIL weights c=%0d got v=%b p=%b e=%h g=%0d b=%b want v=%b p=%b e=%h g=%0d b=%b", c, valid_o, pop_o, element_o, grant_idx_o, busy_o, exp_valid, exp_pop, exp_elem, exp_grant, exp_busy);
      end
      if (pop_o != '0) begin
        want = (npop == 0) ? 0 : (npop <= 15) ? 1 : 2;
        checks++;
        if (pop_o !== (4'b0001 << want)) begin
          errors++;
          $display("FAIL weights_seq pop#%0d got %b want %b", npop, pop_o, 4'b0001 << want);
        end
        npop++;
      end
      commit();
    end
    checks++;
    if (npop != 17) begin errors++; $display("FAIL weights_pops got %0d want 17", npop); end
  endtask

  task automatic test_backpressure();
    int npop;
    elem_t first;
    do_reset();
    w_r[3] = 4'd3;
    first = elem_t'(seqv);
    for (int i = 0; i < 4; i++) push(3);
    npop = 0;
    for (int c = 0; c < 10; c++) begin
      ready_r = (c >= 6);
      drive();
      checks++;
      if (valid_o !== exp_valid || pop_o !== exp_pop || element_o !== exp_elem || grant_idx_o !== exp_grant || busy_o !== exp_busy) begin
        errors++;
        $display("FAIL bp c=%0d got v=%b p=%b e=%h g=%0d b=%b want v=%b p=%b e=%h g=%0d b=%b", c, valid_o, pop_o, element_o, grant_idx_o, busy_o, exp_valid, exp_pop, exp_elem, exp_grant, exp_busy);
      end
      if (c >= 1 && c <= 5) begin
        checks++;
        if (valid_o !== 1'b1 || element_o !== first || pop_o !== '0) begin
          errors++;
          $display("FAIL bp_hold c=%0d got v=%b e=%h p=%b want v=1 e=%h p=0", c, valid_o, element_o, pop_o, first);
        end
      end
      if (pop_o[3]) npop++;
      commit();
    end
    checks++;
    if (npop != 3) begin errors++; $display("FAIL bp_pops got %0d want 3", npop); end
  endtask

  task automatic test_early_drain();
    int npop;
    do_reset();
    w_r[1] = 4'd4;
    push(1); push(1); push(3);
    npop = 0;
    for (int c = 0; c < 7; c++) begin
      drive();
      checks++;
      if (valid_o !== exp_valid || pop_o !== exp_pop || element_o !== exp_elem || grant_idx_o !== exp_grant || busy_o !== exp_busy) begin
        errors++;
        $display("FAIL drain c=%0d got v=%b p=%b e=%h g=%0d b=%b want v=%b p=%b e=%h g=%0d b=%b", c, valid_o, pop_o, element_o, grant_idx_o, busy_o, exp_valid, exp_pop, exp_elem, exp_grant, exp_busy);
      end
      if (pop_o[1]) npop++;
      if (c == 3) begin
        checks++;
        if (valid_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL drain_empty got v=%b b=%b want v=0 b=1", valid_o, busy_o); end
      end
      if (c == 5) begin
        checks++;
        if (grant_idx_o !== 2'd3 || pop_o !== 4'b1000) begin errors++; $display("FAIL drain_next got g=%0d p=%b want g=3 p=1000", grant_idx_o, pop_o); end
      end
      commit();
    end
    checks++;
    if (npop != 2) begin errors++; $display("FAIL drain_pops got %0d want 2", npop); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    w_r[2] = 4'd3;
    push(1);
    for (int i = 0; i < 5; i++) push(2);
    push(3); push(3);
    for (int c = 0; c < 7; c++) begin
      rst_r = (c == 4);
      if (c == 5) push(1);
      drive();
      checks++;
      if (valid_o !== exp_valid || pop_o !== exp_pop || element_o !== exp_elem || grant_idx_o !== exp_grant || busy_o !== exp_busy) begin
        errors++;
        $display("FAIL rstmid c=%0d got v=%b p=%b e=%h g=%0d b=%b want v=%b p=%b e=%h g=%0d b=%b", c, valid_o, pop_o, element_o, grant_idx_o, busy_o, exp_valid, exp_pop, exp_elem, exp_grant, exp_busy);
      end
      if (c == 4) begin
        checks++;
        if (pop_o !== '0 || valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_kill got p=%b v=%b want p=0 v=0", pop_o, valid_o); end
      end
      if (c == 6) begin
        checks++;
        if (grant_idx_o !== 2'd1 || valid_o !== 1'b1) begin errors++; $display("FAIL rstmid_regrant got g=%0d v=%b want g=1 v=1", grant_idx_o, valid_o); end
      end
      commit();
    end
    rst_r = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int s = 0; s < N; s++)
        if ((wr[s] - rd[s]) < 12 && $urandom_range(3) == 0) push(s);
      if (c % 50 == 0)
        for (int s = 0; s < N; s++) w_r[s] = WW'($urandom);
      ready_r = ($urandom_range(3) != 0);
      rst_r   = ($urandom_range(199) == 0);
      drive();
      checks++;
      if (valid_o !== exp_valid || pop_o !== exp_pop || element_o !== exp_elem || grant_idx_o !== exp_grant || busy_o !== exp_busy) begin
        errors++;
        $display("FAIL random c=%0d got v=%b p=%b e=%h g=%0d b=%b want v=%b p=%b e=%h g=%0d b=%b", c, valid_o, pop_o, element_o, grant_idx_o, busy_o, exp_valid, exp_pop, exp_elem, exp_grant, exp_busy);
      end
      commit();
    end
    rst_r = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    ready_i = 1'b0;
    empty_i = '1;
    for (int s = 0; s < N; s++) begin element_i[s] = '0; weight_i[s] = '0; w_r[s] = '0; end
    clear_fifos();
    test_reset();
    test_single_source();
    test_round_robin();
    test_weights();
    test_backpressure();
    test_early_drain();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
